// File: rtl/fb_line_scheduler.sv
`timescale 1ns/1ps
// Frame-buffer port arbiter: prefetches the next visible line into a ping-pong line buffer
// during hblank, and grants PPU writes in otherwise idle cycles.
module fb_line_scheduler #(
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240,
    parameter int V_LAST   = 794,
    parameter int PIX_W    = 6,
    parameter int FB_LAT   = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [10:0]      DrawX,
    input  logic [10:0]      DrawY,
    input  logic             ppu_wr_req,
    input  logic [15:0]      ppu_wr_addr,
    input  logic [PIX_W-1:0] ppu_wr_data,
    output logic             ppu_wr_ack,
    output logic [15:0]      fb_addr,
    output logic             fb_we,
    output logic [PIX_W-1:0] fb_wdata,
    input  logic [PIX_W-1:0] fb_rdata,
    output logic [PIX_W-1:0] pixel,
    output logic             underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       line_q, line_d;
    logic [11:0]      target;
    logic             trigger, grant, issue, drain_done;
    logic [FB_LAT-1:0] pipe_vld_q;
    logic [7:0]       pipe_cnt_q [FB_LAT];
    logic [1:0]       valid_q;
    logic [7:0]       tag_q [2];
    logic             armed_q;
    logic [PIX_W-1:0] linebuf_q [2][256];
    logic [PIX_W-1:0] pixel_q;
    logic             underrun_q;

    assign target     = (DrawY == 11'(V_LAST)) ? 12'd0 : {1'b0, DrawY} + 12'd1;
    assign trigger    = (state_q == IDLE) && (DrawX == 11'(H_ACTIVE)) && (target < 12'(V_ACTIVE));
    // Gated by Reset so a held request cannot be acked while the block is in reset.
    assign grant      = (state_q == IDLE) && !trigger && ppu_wr_req && !Reset;
    assign issue      = (state_q == FETCH);
    assign drain_done = (state_q == DRAIN) && (cnt_q == 8'(FB_LAT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = FETCH;
                    cnt_d   = 8'd0;
                    line_d  = target[7:0];
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (drain_done) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ppu_wr_ack = grant;
        fb_we      = grant;
        fb_wdata   = grant ? ppu_wr_data : '0;
        fb_addr    = 16'd0;
        if (issue)      fb_addr = {line_q, cnt_q};
        else if (grant) fb_addr = ppu_wr_addr;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            line_q     <= 8'd0;
            pipe_vld_q <= '0;
            for (int i = 0; i < FB_LAT; i++) pipe_cnt_q[i] <= 8'd0;
            valid_q    <= 2'b00;
            tag_q[0]   <= 8'd0;
            tag_q[1]   <= 8'd0;
            armed_q    <= 1'b0;
            pixel_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            // Delay pipe tags each issued address so the returning word lands at its column.
            for (int i = FB_LAT - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_cnt_q[i] <= pipe_cnt_q[i-1];
            end
            pipe_vld_q[0] <= issue;
            pipe_cnt_q[0] <= cnt_q;
            if (trigger) valid_q[target[0]] <= 1'b0;
            if (drain_done) begin
                valid_q[line_q[0]] <= 1'b1;
                tag_q[line_q[0]]   <= line_q;
                if (line_q == 8'd0) armed_q <= 1'b1;
            end
            if ((DrawX < 11'(H_ACTIVE)) && (DrawY < 11'(V_ACTIVE)))
                pixel_q <= linebuf_q[DrawY[0]][DrawX[7:0]];
            else
                pixel_q <= '0;
            if ((DrawX == 11'd0) && (DrawY < 11'(V_ACTIVE)) && armed_q &&
                (!valid_q[DrawY[0]] || (tag_q[DrawY[0]] != DrawY[7:0])))
                underrun_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (pipe_vld_q[FB_LAT-1])
            linebuf_q[line_q[0]][pipe_cnt_q[FB_LAT-1]] <= fb_rdata;
    end

    assign pixel    = pixel_q;
    assign underrun = underrun_q;

endmodule

// File: doc/fb_line_scheduler.md
# fb_line_scheduler

Frame-buffer access scheduler between the NES PPU pixel writer and the VGA scan-out path. It owns the single port of the 256x240 frame-buffer RAM and arbitrates it between PPU pixel writes and display line prefetches. Each horizontal blanking interval it copies the next visible line into a ping-pong line buffer, which the display then reads at DrawX/DrawY from the VGA timing generator. Prefetch always wins the RAM port, and PPU writes stall through a req/ack handshake.

## Interface
- H_ACTIVE, 256, visible pixels per line
- V_ACTIVE, 240, visible lines per frame
- V_LAST, 794, last line index of the timing generator (vertical counter wrap value)
- PIX_W, 6, pixel width (NES palette index)
- FB_LAT, 2, frame-buffer read latency in cycles (address to fb_rdata)
- Clk  in  1  pixel clock, same clock as the timing generator
- Reset  in  1  asynchronous, active-high
- DrawX  in  11  current horizontal counter
- DrawY  in  11  current vertical counter
- ppu_wr_req  in  1  PPU write request; held with addr/data until ack
- ppu_wr_addr  in  16  {y[7:0], x[7:0]}
- ppu_wr_data  in  PIX_W  pixel to write
- ppu_wr_ack  out  1  one-cycle grant; the write happens this cycle
- fb_addr  out  16  frame-buffer address
- fb_we  out  1  frame-buffer write enable
- fb_wdata  out  PIX_W  frame-buffer write data
- fb_rdata  in  PIX_W  frame-buffer read data, valid FB_LAT cycles after address
- pixel  out  PIX_W  registered display pixel; 0 outside the active area
- underrun  out  1  sticky: displayed line was not fully fetched

## Operation
- FSM states: IDLE, FETCH, DRAIN. Reset state is IDLE.
- Target line T is defined as follows:
  - T = 0 when DrawY == V_LAST; otherwise T = DrawY + 1.
  - The trigger fires in the cycle where DrawX == H_ACTIVE, T < V_ACTIVE and the state is IDLE.
- Trigger (IDLE -> FETCH):
  - Load cnt = 0 and latch T[7:0] as line L.
  - Clear valid[L[0]].
- FETCH:
  - Each cycle drive fb_addr = {L, cnt}, fb_we = 0, then increment cnt.
  - After cnt = 255 is issued, go to DRAIN.
- Return path: a delay pipe of depth FB_LAT carries {issue-valid, cnt}. Each returning fb_rdata is written to linebuf[L[0]][cnt_d].
- DRAIN:
  - Lasts FB_LAT cycles.
  - On exit, set valid[L[0]] = 1, tag[L[0]] = L, and set armed = 1 when L == 0.
  - Return to IDLE.
- PPU writes:
  - Granted only in IDLE, and only when no trigger fires that cycle.
  - On a grant, in the same cycle (combinational): fb_we = 1, fb_addr = ppu_wr_addr, fb_wdata = ppu_wr_data, ppu_wr_ack = 1.
  - Otherwise ppu_wr_ack = 0. The requester holds its signals until ack.
  - A request held across consecutive IDLE cycles is granted every cycle. The requester deasserts req in the cycle after ack to issue a single write.
- fb_addr = 0 and fb_wdata = 0 when neither fetch nor grant is active.
- Display path:
  - Registered every cycle: pixel <= linebuf[DrawY[0]][DrawX[7:0]] when DrawX < H_ACTIVE and DrawY < V_ACTIVE; else 0.
- Underrun:
  - Checked at DrawX == 0 with DrawY < V_ACTIVE and armed == 1.
  - If !valid[DrawY[0]] or tag[DrawY[0]] != DrawY[7:0], set underrun <= 1.
  - underrun is cleared only by Reset.
- Line buffer: 2 x 256 x PIX_W, with a write port (fetch) and an independent read port (display).

## Timing
- Reset is asynchronous. While Reset is high:
  - State = IDLE, cnt = 0, delay pipe flushed, valid = 2'b00, armed = 0.
  - pixel = 0, underrun = 0, ppu_wr_ack = 0, fb_we = 0, fb_addr = 0, fb_wdata = 0.
- Reset mid-fetch aborts the fetch. The partial line stays invalid.
- Fetch occupancy: 256 + FB_LAT cycles, starting the cycle after the trigger. The first fb_addr appears at DrawX = H_ACTIVE + 1.
- The whole fetch fits inside horizontal blanking of any line with at least H_ACTIVE + 256 + FB_LAT + 1 cycles.
- Worst-case PPU write stall: 257 + FB_LAT cycles after req.
- Simultaneous trigger and req: fetch wins, and ack stays 0 until the cycle after DRAIN exits.
- Pixel latency: 1 cycle. The pixel for (DrawX, DrawY) appears the cycle after those inputs.
- No fetch is triggered on DrawY = V_ACTIVE - 1 (T = 240) or during vertical blanking, except on DrawY = V_LAST, which fetches line 0.
- Address width rule: T[7:0] and cnt[7:0] are concatenated directly, with no multiply.

## Test plan
- Reset held, then released with DrawX = DrawY = 0 -> all outputs 0, state IDLE; no underrun on frame 0 because armed = 0.
- Fill the RAM model with data = addr[5:0] ^ addr[13:8]; drive DrawY = 4, DrawX = 256 -> fb_addr 0x0500..0x05FF on 256 consecutive cycles. On line 5, pixel at DrawX = k+1 equals (k ^ 5) & 0x3F.
- IDLE with ppu_wr_req = 1, addr 0x1234, data 0x2A -> same cycle: fb_we = 1, fb_addr = 0x1234, fb_wdata = 0x2A, ppu_wr_ack = 1.
- Assert req in the trigger cycle (DrawY = 9, DrawX = 256) -> ack stays 0 for 256 + FB_LAT + 1 cycles, then ack = 1 with fb_we = 1.
- Wrap: DrawY = 794, DrawX = 256 -> fetch of 0x0000..0x00FF. DrawY = 239, DrawX = 256 -> no fetch and fb_addr stays 0.
- After a full frame (armed = 1), jump DrawY from 9 to 10 while skipping DrawX = 256 of line 9 -> underrun = 1 from the cycle after DrawX = 0 of line 10, and it stays 1 until Reset.
